// File: rtl/midi_rx_fifo_core.sv
// MIDI input core: 16x-oversampled 8N1 receiver, running-status parser with channel
// filter, and a Note On/Off event FIFO behind the slot register bus.
module midi_rx_fifo_core #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 31250,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic        data_in
);
  localparam int DIV = CLK_HZ / (BAUD * 16);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_t;
  typedef enum logic [1:0] {P_WAIT_STATUS, P_WAIT_D1, P_WAIT_D2} ps_t;

  // ---------------- synchroniser and oversample tick ----------------
  logic          r_sync1, r_sync2, r_prev;
  logic [TW-1:0] r_div;
  logic          w_tick, w_fall;

  assign w_tick = (r_div == TW'(DIV - 1));
  assign w_fall = r_prev & ~r_sync2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
      r_div   <= '0;
    end else begin
      r_sync1 <= data_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_div   <= w_tick ? '0 : r_div + TW'(1);
    end
  end

  // ---------------- receiver ----------------
  rx_t        r_rx, w_rx_nx;
  logic [3:0] r_tcnt, w_tcnt_nx;
  logic [2:0] r_bitn, w_bitn_nx;
  logic [7:0] r_shift, w_shift_nx;
  logic       w_byte_ok, w_frame_err;
  logic       r_byte_stb;
  logic [7:0] r_byte, r_raw;

  always_comb begin
    w_rx_nx     = r_rx;
    w_tcnt_nx   = r_tcnt;
    w_bitn_nx   = r_bitn;
    w_shift_nx  = r_shift;
    w_byte_ok   = 1'b0;
    w_frame_err = 1'b0;
    case (r_rx)
      RX_IDLE: if (w_fall) begin
        w_tcnt_nx = '0;
        w_rx_nx   = RX_START;
      end
      RX_START: if (w_tick) begin
        if (r_tcnt == 4'd7) begin
          w_tcnt_nx = '0;
          w_bitn_nx = '0;
          w_rx_nx   = r_sync2 ? RX_IDLE : RX_DATA;
        end else w_tcnt_nx = r_tcnt + 4'd1;
      end
      RX_DATA: if (w_tick) begin
        if (r_tcnt == 4'd15) begin
          w_tcnt_nx  = '0;
          w_shift_nx = {r_sync2, r_shift[7:1]};
          w_bitn_nx  = r_bitn + 3'd1;
          if (r_bitn == 3'd7) w_rx_nx = RX_STOP;
        end else w_tcnt_nx = r_tcnt + 4'd1;
      end
      RX_STOP: if (w_tick) begin
        if (r_tcnt == 4'd15) begin
          w_tcnt_nx = '0;
          if (r_sync2) begin
            w_byte_ok = 1'b1;
            w_rx_nx   = RX_IDLE;
          end else begin
            w_frame_err = 1'b1;
            w_rx_nx     = RX_BREAK;
          end
        end else w_tcnt_nx = r_tcnt + 4'd1;
      end
      RX_BREAK: if (r_sync2) w_rx_nx = RX_IDLE;
      default:  w_rx_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx       <= RX_IDLE;
      r_tcnt     <= '0;
      r_bitn     <= '0;
      r_shift    <= '0;
      r_byte_stb <= 1'b0;
      r_byte     <= '0;
      r_raw      <= '0;
    end else begin
      r_rx       <= w_rx_nx;
      r_tcnt     <= w_tcnt_nx;
      r_bitn     <= w_bitn_nx;
      r_shift    <= w_shift_nx;
      r_byte_stb <= w_byte_ok;
      if (w_byte_ok) begin
        r_byte <= r_shift;
        r_raw  <= r_shift;
      end
    end
  end

  // ---------------- parser ----------------
  ps_t        r_ps, w_ps_nx;
  logic       r_rs_vld, w_rs_vld_nx;
  logic       r_rs_on, w_rs_on_nx;
  logic [3:0] r_chan, w_chan_nx;
  logic [6:0] r_note, w_note_nx;
  logic [6:0] r_vel, w_vel_nx;
  logic       w_emit, r_evt_pend;

  always_comb begin
    w_ps_nx     = r_ps;
    w_rs_vld_nx = r_rs_vld;
    w_rs_on_nx  = r_rs_on;
    w_chan_nx   = r_chan;
    w_note_nx   = r_note;
    w_vel_nx    = r_vel;
    w_emit      = 1'b0;
    if (r_byte_stb) begin
      if (r_byte >= 8'hF8) begin
        // realtime bytes are transparent to the message in progress
      end else if (r_byte[7:5] == 3'b100) begin
        w_rs_vld_nx = 1'b1;
        w_rs_on_nx  = r_byte[4];
        w_chan_nx   = r_byte[3:0];
        w_ps_nx     = P_WAIT_D1;
      end else if (r_byte[7]) begin
        w_rs_vld_nx = 1'b0;
        w_ps_nx     = P_WAIT_STATUS;
      end else begin
        case (r_ps)
          P_WAIT_STATUS: if (r_rs_vld) begin
            w_note_nx = r_byte[6:0];
            w_ps_nx   = P_WAIT_D2;
          end
          P_WAIT_D1: begin
            w_note_nx = r_byte[6:0];
            w_ps_nx   = P_WAIT_D2;
          end
          P_WAIT_D2: begin
            w_vel_nx = r_byte[6:0];
            w_emit   = 1'b1;
            w_ps_nx  = P_WAIT_D1;
          end
          default: w_ps_nx = P_WAIT_STATUS;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ps       <= P_WAIT_STATUS;
      r_rs_vld   <= 1'b0;
      r_rs_on    <= 1'b0;
      r_chan     <= '0;
      r_note     <= '0;
      r_vel      <= '0;
      r_evt_pend <= 1'b0;
    end else begin
      r_ps       <= w_ps_nx;
      r_rs_vld   <= w_rs_vld_nx;
      r_rs_on    <= w_rs_on_nx;
      r_chan     <= w_chan_nx;
      r_note     <= w_note_nx;
      r_vel      <= w_vel_nx;
      r_evt_pend <= w_emit;
    end
  end

  // ---------------- control, flags, FIFO ----------------
  logic          r_en, r_ovf, r_ferr;
  logic [15:0]   r_mask;
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [31:0]   w_evt;
  logic          w_wr, w_flush, w_pop, w_push, w_evt_ok, w_full, w_empty, w_ovf_set;
  logic [1:0]    w_rx_busy;
  logic          w_unused;

  assign w_evt     = {1'b1, 6'b0, r_rs_on & (r_vel != 7'd0), 4'b0, r_chan,
                      1'b0, r_note, 1'b0, r_vel};
  assign w_wr      = cs & write;
  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == (AW+1)'(FIFO_DEPTH));
  assign w_flush   = w_wr & (addr == 5'd3) & wr_data[2];
  assign w_pop     = cs & read & (addr == 5'd0) & ~w_empty & ~w_flush;
  assign w_evt_ok  = r_evt_pend & r_en & r_mask[r_chan];
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign w_push    = w_evt_ok & (~w_full | w_pop) & ~w_flush;
  assign w_ovf_set = w_evt_ok & w_full & ~w_pop & ~w_flush;
  assign w_unused  = &{1'b0, wr_data[15:3]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en   <= 1'b1;
      r_mask <= 16'hFFFF;
      r_ovf  <= 1'b0;
      r_ferr <= 1'b0;
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr && addr == 5'd2) begin
        r_en   <= wr_data[0];
        r_mask <= wr_data[31:16];
      end
      if (w_ovf_set) r_ovf <= 1'b1;
      else if (w_wr && addr == 5'd3 && wr_data[0]) r_ovf <= 1'b0;
      if (w_frame_err) r_ferr <= 1'b1;
      else if (w_wr && addr == 5'd3 && wr_data[1]) r_ferr <= 1'b0;
      if (w_flush) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_push) r_wp <= r_wp + AW'(1);
        if (w_pop)  r_rp <= r_rp + AW'(1);
        case ({w_push, w_pop})
          2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
          2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= w_evt;
  end

  always_comb begin
    case (r_rx)
      RX_IDLE:  w_rx_busy = 2'd0;
      RX_START: w_rx_busy = 2'd1;
      RX_DATA:  w_rx_busy = 2'd2;
      default:  w_rx_busy = 2'd3;
    endcase
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      5'd0: rd_data = w_empty ? 32'h0 : r_mem[r_rp];
      5'd1: rd_data = {16'b0, w_rx_busy, r_ps != P_WAIT_STATUS, r_ferr, r_ovf,
                       w_full, w_empty, 9'(r_cnt)};
      5'd2: rd_data = {r_mask, 15'b0, r_en};
      5'd4: rd_data = {24'b0, r_raw};
      default: rd_data = '0;
    endcase
  end
endmodule
